// File: rtl/compress_pkg.sv
// Shared compression constants, token layout and compressor FSM states.
// OPCODE/ENCODE_LEN must stay identical to the decompressor's values.
package compress_pkg;

  localparam int WORD_W = 32;
  localparam int ENCODE_LEN = 4;
  localparam logic [ENCODE_LEN-1:0] OPCODE = 4'b1111;

  typedef struct packed {
    logic [ENCODE_LEN-1:0]        marker;
    logic [WORD_W-ENCODE_LEN-1:0] offset;
  } token_t;

  typedef enum logic {
    EMPTY,
    HELD
  } state_t;

endpackage

// File: rtl/pair_table.sv
// Pair table: word storage with per-word valid bits, 1-cycle write port and
// a combinational lowest-index match of {first, second} against every pair.
module pair_table #(
  parameter int WIDTH = 32,
  parameter int PAIRS = 51,
  parameter int AW    = $clog2(2*PAIRS),
  parameter int IW    = $clog2(PAIRS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] second,
  output logic             hit,
  output logic [IW-1:0]    index
);

  localparam int DEPTH = 2*PAIRS;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic             wr_ok;

  assign wr_ok = we && (int'(addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld <= '0;
    end else if (wr_ok) begin
      vld[addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[addr] <= wdata;
    end
  end

  // Ascending scan that locks on the first hit gives lowest-index priority.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int unsigned k = 0; k < PAIRS; k++) begin
      if (!hit && vld[2*k] && vld[2*k+1] &&
          mem[2*k] == first && mem[2*k+1] == second) begin
        hit   = 1'b1;
        index = IW'(k);
      end
    end
  end

endmodule

// File: rtl/instr_compressor.sv
// Instruction-pair compressor: replaces table-listed consecutive pairs with
// {OPCODE, byte offset} tokens. Optional counters under COMPRESS_STATS_EN.
module instr_compressor #(
  parameter int WIDTH = compress_pkg::WORD_W,
  parameter int ENCODE_LEN = compress_pkg::ENCODE_LEN,
  parameter logic [ENCODE_LEN-1:0] OPCODE = compress_pkg::OPCODE,
  parameter int PAIRS = 51,
  parameter int AW = $clog2(2*PAIRS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             tbl_we,
  input  logic [AW-1:0]    tbl_addr,
  input  logic [WIDTH-1:0] tbl_wdata,
  output logic             collide,
  output logic             idle
`ifdef COMPRESS_STATS_EN
  ,
  output logic [31:0]      in_count,
  output logic [31:0]      token_count
`endif
);

  import compress_pkg::*;

  localparam int IW = $clog2(PAIRS);

  state_t           state, state_next;
  logic [WIDTH-1:0] held;
  logic             hit;
  logic [IW-1:0]    hit_idx;
  logic             slot_free, in_fire;
  logic             load_tok, load_raw, take_in;
  token_t           tok;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free;
  assign in_fire   = in_valid && in_ready;
  assign idle      = (state == EMPTY) && !out_valid;

  pair_table #(
    .WIDTH (WIDTH),
    .PAIRS (PAIRS),
    .AW    (AW),
    .IW    (IW)
  ) u_table (
    .clk    (clk),
    .reset  (reset),
    .we     (tbl_we),
    .addr   (tbl_addr),
    .wdata  (tbl_wdata),
    .first  (held),
    .second (in_data),
    .hit    (hit),
    .index  (hit_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (in_fire) state_next = HELD;
      HELD: begin
        if (in_fire) begin
          state_next = hit ? EMPTY : HELD;
        end else if (flush && slot_free) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // A flush with in_valid high never drains: the pending pair goes first.
  always_comb begin
    load_tok = 1'b0;
    load_raw = 1'b0;
    if (state == HELD) begin
      load_tok = in_fire && hit;
      load_raw = (in_fire && !hit) || (flush && !in_valid && slot_free);
    end
    take_in    = in_fire && !load_tok;
    tok.marker = OPCODE;
    tok.offset = '0;
    tok.offset[IW+2:0] = {hit_idx, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      collide   <= 1'b0;
      held      <= '0;
    end else begin
      collide <= load_raw && (held[WIDTH-1 -: ENCODE_LEN] == OPCODE);
      if (load_tok) begin
        out_data  <= WIDTH'(tok);
        out_valid <= 1'b1;
      end else if (load_raw) begin
        out_data  <= held;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (take_in) begin
        held <= in_data;
      end else if (load_tok || load_raw) begin
        held <= '0;
      end
    end
  end

`ifdef COMPRESS_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_count    <= '0;
      token_count <= '0;
    end else begin
      if (in_fire && in_count != '1) begin
        in_count <= in_count + 32'd1;
      end
      if (load_tok && token_count != '1) begin
        token_count <= token_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_compressor.sv
// Randomized self-checking bench for instr_compressor: greedy pairing model
// over a word-level table image, scoreboard queue of expected output words.
module tb_instr_compressor;

  localparam int PAIRS = 51;
  localparam int DEPTH = 2*PAIRS;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          out_ready = 1'b0;
  logic          tbl_we = 1'b0;
  logic [AW-1:0] tbl_addr = '0;
  logic [31:0]   tbl_wdata = '0;
  logic          collide;
  logic          idle;
`ifdef COMPRESS_STATS_EN
  logic [31:0]   in_count;
  logic [31:0]   token_count;
`endif

  instr_compressor #(
    .WIDTH (32),
    .PAIRS (PAIRS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_wdata (tbl_wdata),
    .collide   (collide),
    .idle      (idle)
`ifdef COMPRESS_STATS_EN
    ,
    .in_count    (in_count),
    .token_count (token_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    bit          tok;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        expq[$];
  logic [31:0] blk[$];
  logic [31:0] tw[DEPTH];
  bit          tv[DEPTH];
  int          stall_cyc = 0;
  int          acc_count = 0;
  int          tok_count = 0;
  logic [31:0] pool[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] w, input bit tok);
    exp_t e;
    e.w   = w;
    e.tok = tok;
    expq.push_back(e);
  endtask

  // Lowest pair index whose two words are both written and equal {a, b}.
  function automatic int find_pair(input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < PAIRS; k++)
      if (tv[2*k] && tv[2*k+1] && tw[2*k] == a && tw[2*k+1] == b) return k;
    return -1;
  endfunction

  task automatic model_block();
    int i = 0;
    int k;
    while (i < blk.size()) begin
      k = (i + 1 < blk.size()) ? find_pair(blk[i], blk[i+1]) : -1;
      if (k >= 0) begin
        push_exp({4'hF, 28'(k * 8)}, 1'b1);
        tok_count++;
        i += 2;
      end else begin
        push_exp(blk[i], 1'b0);
        i++;
      end
    end
  endtask

  // Output monitor: scoreboard pop on each newly loaded word, hold checks.
  logic        pv = 1'b0, pr = 1'b0;
  logic [31:0] pdata = '0;
  always @(negedge clk) begin
    exp_t e;
    logic newword;
    if (!reset) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      newword = out_valid && (!pv || pr);
      if (pv && !pr) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, pdata);
      end
      if (newword) begin
        if (expq.size() == 0) begin
          check("unexpected_word", out_data, 32'hxxxxxxxx);
        end else begin
          e = expq.pop_front();
          check("out_data", out_data, e.w);
          check("collide", 32'(collide), 32'(!e.tok && e.w[31:28] == 4'hF));
        end
      end else begin
        check("collide_quiet", 32'(collide), 32'd0);
      end
      if (stall_cyc > 0) begin
        out_ready = 1'b0;
        stall_cyc--;
      end else begin
        out_ready = ($urandom_range(0, 9) < 7);
      end
      pv    = out_valid;
      pr    = out_ready;
      pdata = out_data;
      #1;
      check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic tbl_write(input int a, input logic [31:0] d);
    cyc();
    in_valid  = 1'b0;
    tbl_we    = 1'b1;
    tbl_addr  = AW'(a);
    tbl_wdata = d;
    cyc();
    tbl_we = 1'b0;
    if (a < DEPTH) begin
      tw[a] = d;
      tv[a] = 1'b1;
    end
  endtask

  task automatic tbl_pair(input int k, input logic [31:0] a, input logic [31:0] b);
    tbl_write(2*k, a);
    tbl_write(2*k + 1, b);
  endtask

  task automatic send_word(input logic [31:0] w);
    int   n = 0;
    logic rdy;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    forever begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 500) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
      cyc();
    end
    acc_count++;
  endtask

  task automatic drain();
    int n = 0;
    cyc();
    in_valid = 1'b0;
    flush    = 1'b1;
    while (!idle && n < 500) begin
      cyc();
      n++;
    end
    flush = 1'b0;
    check("drain_idle", 32'(idle), 32'd1);
    check("queue_empty", 32'(expq.size()), 32'd0);
`ifdef COMPRESS_STATS_EN
    check("in_count", in_count, 32'(acc_count));
    check("token_count", token_count, 32'(tok_count));
`endif
  endtask

  task automatic run_block(input bit use_model, input int stall_at);
    if (use_model) model_block();
    foreach (blk[i]) begin
      send_word(blk[i]);
      if (i == stall_at) stall_cyc = 5;
    end
    drain();
  endtask

  initial begin
    int k;
    for (int i = 0; i < DEPTH; i++) begin
      tw[i] = '0;
      tv[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_collide", 32'(collide), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    reset = 1'b1;

    // Empty table: everything passes through raw, in order.
    blk.delete();
    blk.push_back(32'hAAAAAAAA); blk.push_back(32'hBBBBBBBB); blk.push_back(32'hCCCCCCCC);
    push_exp(32'hAAAAAAAA, 0); push_exp(32'hBBBBBBBB, 0); push_exp(32'hCCCCCCCC, 0);
    run_block(0, -1);

    tbl_pair(0, 32'h00A00093, 32'h00100113);
    blk.delete();
    blk.push_back(32'h00A00093); blk.push_back(32'h00100113);
    push_exp(32'hF0000000, 1);
    tok_count++;
    run_block(0, -1);

    tbl_pair(3, 32'h11111111, 32'h22222222);
    blk.delete();
    blk.push_back(32'h33333333); blk.push_back(32'h11111111); blk.push_back(32'h22222222);
    push_exp(32'h33333333, 0); push_exp(32'hF0000018, 1);
    tok_count++;
    run_block(0, -1);

    // Stall the output for 5 cycles mid-stream.
    blk.delete();
    for (int i = 0; i < 6; i++) blk.push_back(32'h0C000000 + 32'(i));
    run_block(1, 1);

    blk.delete();
    blk.push_back(32'hF1234567); blk.push_back(32'h0BADC0DE);
    push_exp(32'hF1234567, 0); push_exp(32'h0BADC0DE, 0);
    run_block(0, -1);

    // Duplicate pair: lowest index wins; out-of-range writes are dropped.
    tbl_pair(10, 32'h12340001, 32'h12340002);
    tbl_pair(4, 32'h12340001, 32'h12340002);
    tbl_write(102, 32'h44444444);
    tbl_write(127, 32'h44444444);
    blk.delete();
    blk.push_back(32'h12340001); blk.push_back(32'h12340002);
    blk.push_back(32'h11111111); blk.push_back(32'h22222222); blk.push_back(32'h44444444);
    run_block(1, -1);

    for (int i = 0; i < 8; i++) pool[i] = $urandom;
    pool[0][31:28] = 4'hF;
    pool[5][31:28] = 4'hF;
    for (int n = 0; n < 14; n++) begin
      k = $urandom_range(0, PAIRS - 1);
      tbl_write(2*k, pool[$urandom_range(0, 7)]);
      if ($urandom_range(0, 3) != 0) tbl_write(2*k + 1, pool[$urandom_range(0, 7)]);
    end
    for (int n = 0; n < 40; n++) begin
      blk.delete();
      for (int j = $urandom_range(1, 8); j > 0; j--) blk.push_back(pool[$urandom_range(0, 7)]);
      run_block(1, ($urandom_range(0, 3) == 0) ? 1 : -1);
    end

    // Reset while HELD with a pending output word.
    tbl_pair(5, 32'h55550001, 32'h55550002);
    stall_cyc = 50;
    push_exp(32'h77770001, 0);
    send_word(32'h77770001);
    send_word(32'h77770002);
    cyc();
    in_valid = 1'b0;
    reset    = 1'b0;
    cyc();
    expq.delete();
    stall_cyc = 0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_idle", 32'(idle), 32'd1);
    check("mid_rst_out_data", out_data, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) tv[i] = 1'b0;
    acc_count = 0;
    tok_count = 0;
    blk.delete();
    blk.push_back(32'h55550001); blk.push_back(32'h55550002);
    run_block(1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
